// File: rtl/rf_wb_arbiter_pkg.sv
// Shared sizing defaults and the write-port select encoding for rf_wb_arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_ARB_DATA_WIDTH     = 32;
  localparam int RF_ARB_REG_ADDR_WIDTH = 5;
  localparam int RF_ARB_REG_DEPTH      = 32;
  localparam int RF_ARB_FIFO_DEPTH     = 2;
  localparam int RF_ARB_MAX_OUT        = 4;
  localparam int RF_ARB_STARVE_LIMIT   = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_CORE = 2'b01,
    SEL_COP  = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// rf_wb_fifo: small {rd,data} result buffer; pointers carry one extra wrap bit for full/empty.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = RF_ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ARB_REG_ADDR_WIDTH,
  parameter int DEPTH      = RF_ARB_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_rd,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH-1:0] o_head_rd,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_INC = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic                  w_push;
  logic                  w_pop;

  assign w_push      = i_push & ~o_full;
  assign w_pop       = i_pop & ~o_empty;
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_head_rd   = r_rd_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_head_data = r_data_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {(PTR_W+1){1'b0}};
      r_rd_ptr <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr[PTR_W-1:0]]   <= i_push_rd;
      r_data_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regFile write port between core writeback and buffered coprocessor results.
// Defining COP_STARVE_GUARD_EN adds a starvation guard that briefly stalls the core to drain a result.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = RF_ARB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = RF_ARB_REG_ADDR_WIDTH,
  parameter int REG_DEPTH      = RF_ARB_REG_DEPTH,
  parameter int FIFO_DEPTH     = RF_ARB_FIFO_DEPTH,
  parameter int MAX_OUT        = RF_ARB_MAX_OUT,
  parameter int STARVE_LIMIT   = RF_ARB_STARVE_LIMIT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_core_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_core_wb_rd,
  input  logic [DATA_WIDTH-1:0]     i_core_wb_data,
  output logic                      o_core_stall,
  input  logic                      i_cop_issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_cop_issue_rd,
  output logic                      o_cop_issue_ready,
  input  logic                      i_cop_res_valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_cop_res_rd,
  input  logic [DATA_WIDTH-1:0]     i_cop_res_data,
  output logic                      o_cop_res_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_rd,
  output logic                      o_hazard,
  output logic                      o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  output logic [REG_DEPTH-1:0]      o_busy_vec,
  output logic                      o_err_waw
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0]          OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0]          OUT_ONE  = OUT_W'(32'd1);
  localparam logic [OUT_W-1:0]          OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [REG_ADDR_WIDTH-1:0] X0       = {REG_ADDR_WIDTH{1'b0}};

  logic [REG_DEPTH-1:0]      r_busy;
  logic [OUT_W-1:0]          r_outstanding;
  logic                      r_err_waw;
  logic                      r_core_stall;
  logic [REG_DEPTH-1:0]      w_busy_next;
  logic [OUT_W-1:0]          w_out_next;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [REG_ADDR_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0]     w_head_data;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_core_win;
  logic                      w_accept;
  wb_sel_e                   w_sel;

  // x0 is never tracked, so a zero index never reports busy.
  function automatic logic busy_at(input logic [REG_DEPTH-1:0] vec,
                                   input logic [REG_ADDR_WIDTH-1:0] idx);
    return (idx != X0) && vec[idx];
  endfunction

  rf_wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_rd   (i_cop_res_rd),
    .i_push_data (i_cop_res_data),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data)
  );

  assign o_cop_res_ready   = ~w_fifo_full;
  assign o_cop_issue_ready = (r_outstanding < OUT_MAX) &&
                             ((i_cop_issue_rd == X0) || !r_busy[i_cop_issue_rd]);
  assign o_hazard          = busy_at(r_busy, i_dec_rs1) | busy_at(r_busy, i_dec_rs2) |
                             busy_at(r_busy, i_dec_rd);
  assign w_push            = i_cop_res_valid & ~w_fifo_full & ~i_rst;
  assign w_accept          = i_cop_issue_valid & o_cop_issue_ready & ~i_rst;
  assign w_pop             = (w_sel == SEL_COP);
  assign w_core_win        = (w_sel == SEL_CORE);
  assign o_busy_vec        = r_busy;
  assign o_err_waw         = r_err_waw;
  assign o_core_stall      = r_core_stall;

  // A guard stall slot always goes to the buffered result.
  always_comb begin
    w_sel = SEL_NONE;
    if (i_rst) begin
      w_sel = SEL_NONE;
    end else if (r_core_stall && !w_fifo_empty) begin
      w_sel = SEL_COP;
    end else if (i_core_wb_valid) begin
      w_sel = SEL_CORE;
    end else if (!w_fifo_empty) begin
      w_sel = SEL_COP;
    end else begin
      w_sel = SEL_NONE;
    end
  end

  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_waddr = X0;
    o_rf_wdata = {DATA_WIDTH{1'b0}};
    case (w_sel)
      SEL_CORE: begin
        o_rf_we    = (i_core_wb_rd != X0);
        o_rf_waddr = i_core_wb_rd;
        o_rf_wdata = i_core_wb_data;
      end
      SEL_COP: begin
        o_rf_we    = (w_head_rd != X0);
        o_rf_waddr = w_head_rd;
        o_rf_wdata = w_head_data;
      end
      default: begin
        o_rf_we    = 1'b0;
        o_rf_waddr = X0;
        o_rf_wdata = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Scoreboard: an accept and a pop never hit the same rd because ready sees registered busy.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < REG_DEPTH; i++) begin
      if (i == 0) begin
        w_busy_next[i] = 1'b0;
      end else if (w_accept && (i_cop_issue_rd == REG_ADDR_WIDTH'(i))) begin
        w_busy_next[i] = 1'b1;
      end else if (w_pop && (w_head_rd == REG_ADDR_WIDTH'(i))) begin
        w_busy_next[i] = 1'b0;
      end else begin
        w_busy_next[i] = r_busy[i];
      end
    end
    case ({w_accept, w_pop})
      2'b10:   w_out_next = r_outstanding + OUT_ONE;
      2'b01:   w_out_next = (r_outstanding == OUT_ZERO) ? OUT_ZERO : (r_outstanding - OUT_ONE);
      default: w_out_next = r_outstanding;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy        <= {REG_DEPTH{1'b0}};
      r_outstanding <= OUT_ZERO;
      r_err_waw     <= 1'b0;
    end else begin
      r_busy        <= w_busy_next;
      r_outstanding <= w_out_next;
      r_err_waw     <= w_core_win && busy_at(r_busy, i_core_wb_rd);
    end
  end

`ifdef COP_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(32'd1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

  logic [STARVE_W-1:0] r_starve_cnt;

  // Count core wins over a waiting result; the wrap-around win forces one drain slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= {STARVE_W{1'b0}};
      r_core_stall <= 1'b0;
    end else begin
      if (w_pop) begin
        r_starve_cnt <= {STARVE_W{1'b0}};
      end else if (w_core_win && !w_fifo_empty) begin
        r_starve_cnt <= r_starve_cnt + STARVE_ONE;
      end
      r_core_stall <= w_core_win && !w_fifo_empty && (r_starve_cnt == STARVE_LAST);
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_stall <= 1'b0;
    end else begin
      r_core_stall <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then randomized traffic vs a queue-based model.
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int FDEPTH = 2;
  localparam int MAXO = 4;
  localparam int SLIM = 4;
`ifdef COP_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          core_wb_valid;
  logic [AW-1:0] core_wb_rd;
  logic [DW-1:0] core_wb_data;
  logic          core_stall;
  logic          cop_issue_valid;
  logic [AW-1:0] cop_issue_rd;
  logic          cop_issue_ready;
  logic          cop_res_valid;
  logic [AW-1:0] cop_res_rd;
  logic [DW-1:0] cop_res_data;
  logic          cop_res_ready;
  logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          hazard;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NREG-1:0] busy_vec;
  logic          err_waw;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_wb_valid(core_wb_valid), .i_core_wb_rd(core_wb_rd), .i_core_wb_data(core_wb_data),
    .o_core_stall(core_stall),
    .i_cop_issue_valid(cop_issue_valid), .i_cop_issue_rd(cop_issue_rd), .o_cop_issue_ready(cop_issue_ready),
    .i_cop_res_valid(cop_res_valid), .i_cop_res_rd(cop_res_rd), .i_cop_res_data(cop_res_data),
    .o_cop_res_ready(cop_res_ready),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
    .o_hazard(hazard), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_busy_vec(busy_vec), .o_err_waw(err_waw)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: busy set, outstanding count, result queue, ops awaiting results.
  typedef struct {
    int          rd;
    logic [31:0] data;
  } res_t;

  bit   m_busy [NREG];
  int   m_out;
  res_t m_fifo [$];
  int   m_pend [$];
  bit   m_err;
  bit   m_stall;
  int   m_starve;

  function automatic bit m_is_busy(input int idx);
    return (idx != 0) && m_busy[idx];
  endfunction

  // 0 = nobody writes, 1 = core writes, 2 = oldest buffered result writes.
  function automatic int m_writer();
    if (rst) return 0;
    if (m_stall && m_fifo.size() > 0) return 2;
    if (core_wb_valid) return 1;
    if (m_fifo.size() > 0) return 2;
    return 0;
  endfunction

  task automatic idle();
    rst = 1'b0; core_wb_valid = 1'b0; core_wb_rd = '0; core_wb_data = '0;
    cop_issue_valid = 1'b0; cop_issue_rd = '0;
    cop_res_valid = 1'b0; cop_res_rd = '0; cop_res_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  task automatic sample();
    int          who;
    bit          exp_we;
    int          exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_bv;
    @(negedge clk);
    who = m_writer();
    exp_we = 1'b0; exp_addr = 0; exp_data = '0;
    if (who == 1) begin
      exp_we = (core_wb_rd != 0); exp_addr = core_wb_rd; exp_data = core_wb_data;
    end else if (who == 2) begin
      exp_we = (m_fifo[0].rd != 0); exp_addr = m_fifo[0].rd; exp_data = m_fifo[0].data;
    end
    check_eq("rf_we", rf_we, exp_we);
    if (exp_we) begin
      check_eq("rf_waddr", rf_waddr, exp_addr);
      check_eq("rf_wdata", rf_wdata, exp_data);
    end
    for (int i = 0; i < NREG; i++) exp_bv[i] = m_busy[i];
    check_eq("busy_vec", busy_vec, exp_bv);
    check_eq("res_ready", cop_res_ready, m_fifo.size() < FDEPTH);
    check_eq("issue_ready", cop_issue_ready, (m_out < MAXO) && !m_is_busy(cop_issue_rd));
    check_eq("hazard", hazard, m_is_busy(dec_rs1) | m_is_busy(dec_rs2) | m_is_busy(dec_rd));
    check_eq("err_waw", err_waw, m_err);
    check_eq("core_stall", core_stall, m_stall);
  endtask

  task automatic advance();
    int   who;
    int   old_size;
    bit   res_ok;
    bit   iss_ok;
    bit   err_n;
    bit   stall_n;
    res_t e;
    who      = m_writer();
    old_size = m_fifo.size();
    res_ok   = cop_res_valid && (old_size < FDEPTH);
    iss_ok   = cop_issue_valid && (m_out < MAXO) && !m_is_busy(cop_issue_rd);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_out = 0; m_fifo.delete(); m_pend.delete();
      m_err = 1'b0; m_stall = 1'b0; m_starve = 0;
    end else begin
      err_n   = (who == 1) && m_is_busy(core_wb_rd);
      stall_n = GUARD && (who == 1) && (old_size > 0) && (m_starve == SLIM - 1);
      if (who == 2) begin
        e = m_fifo.pop_front();
        if (e.rd != 0) m_busy[e.rd] = 1'b0;
        if (m_out > 0) m_out--;
        m_starve = 0;
      end else if (who == 1 && old_size > 0) begin
        m_starve++;
      end
      if (res_ok) begin
        e.rd = cop_res_rd; e.data = cop_res_data;
        m_fifo.push_back(e);
        if (m_pend.size() > 0) void'(m_pend.pop_front());
      end
      if (iss_ok) begin
        if (cop_issue_rd != 0) m_busy[cop_issue_rd] = 1'b1;
        m_out++;
        m_pend.push_back(cop_issue_rd);
      end
      m_err = err_n; m_stall = stall_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic rand_inputs();
    rst             = ($urandom_range(999) < 5);
    core_wb_valid   = ($urandom_range(99) < 45) && !m_stall;
    core_wb_rd      = AW'($urandom_range(31));
    core_wb_data    = $urandom;
    cop_issue_valid = ($urandom_range(99) < 40);
    cop_issue_rd    = AW'($urandom_range(31));
    if (m_pend.size() > 0 && $urandom_range(99) < 50) begin
      cop_res_valid = 1'b1; cop_res_rd = AW'(m_pend[0]);
    end else begin
      cop_res_valid = 1'b0; cop_res_rd = AW'($urandom_range(31));
    end
    cop_res_data = $urandom;
    dec_rs1 = AW'($urandom_range(31));
    dec_rs2 = AW'($urandom_range(31));
    dec_rd  = AW'($urandom_range(31));
  endtask

  initial begin : main
    int stall_cycles;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_out = 0; m_err = 1'b0; m_stall = 1'b0; m_starve = 0;
    idle();

    // Reset held two cycles with random inputs.
    rand_inputs(); rst = 1'b1; advance();
    rand_inputs(); rst = 1'b1; sample();
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_busy", busy_vec, 32'd0);
    check_eq("rst_res_ready", cop_res_ready, 1'b1);
    check_eq("rst_issue_ready", cop_issue_ready, 1'b1);
    advance();

    // Core-only write passes straight through.
    idle(); core_wb_valid = 1'b1; core_wb_rd = 5'd5; core_wb_data = 32'hDEADBEEF;
    sample();
    check_eq("core_we", rf_we, 1'b1);
    check_eq("core_waddr", rf_waddr, 5);
    check_eq("core_wdata", rf_wdata, 32'hDEADBEEF);
    advance();

    // Scoreboard hazard on rd 7 until its result is written.
    idle(); cop_issue_valid = 1'b1; cop_issue_rd = 5'd7; tick();
    idle(); dec_rs1 = 5'd7; sample(); check_eq("sb_hazard_set", hazard, 1'b1); advance();
    idle(); dec_rs1 = 5'd7; cop_res_valid = 1'b1; cop_res_rd = 5'd7; cop_res_data = 32'h1234; tick();
    idle(); dec_rs1 = 5'd7; sample();
    check_eq("sb_pop_we", rf_we, 1'b1);
    check_eq("sb_pop_addr", rf_waddr, 7);
    check_eq("sb_pop_data", rf_wdata, 32'h1234);
    advance();
    idle(); dec_rs1 = 5'd7; sample();
    check_eq("sb_hazard_clr", hazard, 1'b0);
    check_eq("sb_busy7", busy_vec[7], 1'b0);
    advance();

    // Contention: fill outstanding, fill fifo under core traffic, then drain in order.
    for (int r = 8; r < 12; r++) begin
      idle(); cop_issue_valid = 1'b1; cop_issue_rd = AW'(r); tick();
    end
    idle(); cop_issue_valid = 1'b1; cop_issue_rd = 5'd12; sample();
    check_eq("max_out_ready", cop_issue_ready, 1'b0); advance();
    for (int k = 0; k < 3; k++) begin
      idle(); core_wb_valid = !m_stall; core_wb_rd = AW'(k + 1); core_wb_data = $urandom;
      if (k < 2) begin cop_res_valid = 1'b1; cop_res_rd = AW'(m_pend[0]); cop_res_data = $urandom; end
      sample();
      if (k == 2) check_eq("fifo_full_ready", cop_res_ready, 1'b0);
      advance();
    end
    idle(); sample(); check_eq("drain0_addr", rf_waddr, 8); advance();
    idle(); sample(); check_eq("drain1_addr", rf_waddr, 9); advance();
    for (int k = 0; k < 4; k++) begin
      idle();
      if (m_pend.size() > 0) begin cop_res_valid = 1'b1; cop_res_rd = AW'(m_pend[0]); cop_res_data = $urandom; end
      tick();
    end

    // x0 result is consumed silently; core write to a busy rd flags WAW.
    idle(); cop_issue_valid = 1'b1; cop_issue_rd = 5'd0; tick();
    idle(); cop_res_valid = 1'b1; cop_res_rd = 5'd0; cop_res_data = 32'hA5A5A5A5; tick();
    idle(); sample(); check_eq("x0_we", rf_we, 1'b0); advance();
    idle(); sample(); check_eq("x0_drained", cop_issue_ready, 1'b1); advance();
    idle(); cop_issue_valid = 1'b1; cop_issue_rd = 5'd7; tick();
    idle(); core_wb_valid = 1'b1; core_wb_rd = 5'd7; core_wb_data = 32'h77; sample();
    check_eq("waw_write", rf_we, 1'b1); advance();
    idle(); sample(); check_eq("waw_pulse", err_waw, 1'b1); advance();
    idle(); sample(); check_eq("waw_drop", err_waw, 1'b0); advance();
    idle(); cop_res_valid = 1'b1; cop_res_rd = 5'd7; cop_res_data = 32'h99; tick();
    idle(); tick();

    // Starvation: result waiting while core writes every cycle.
    idle(); cop_issue_valid = 1'b1; cop_issue_rd = 5'd20; tick();
    idle(); cop_res_valid = 1'b1; cop_res_rd = 5'd20; cop_res_data = 32'h2020; tick();
    stall_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      idle(); core_wb_valid = !m_stall; core_wb_rd = 5'd3; core_wb_data = $urandom;
      sample();
      if (core_stall) stall_cycles++;
      advance();
    end
    check_eq("stall_cycles", stall_cycles, GUARD ? 1 : 0);
    idle(); tick();
    idle(); tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
